// File: rtl/pacote_controle.sv
// Shared encodings for the multi-cycle control unit:
// opcodes, FSM states, PC source and ALU operation codes.
package pacote_controle;

    typedef enum logic [2:0] {
        BUSCA      = 3'd0,
        DECODIFICA = 3'd1,
        EXECUTA    = 3'd2,
        MEMORIA    = 3'd3,
        ESCRITA    = 3'd4,
        PARADO     = 3'd5
    } estado_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_LI   = 3'b010;
    localparam logic [2:0] OP_LW   = 3'b011;
    localparam logic [2:0] OP_SW   = 3'b100;
    localparam logic [2:0] OP_BEQ  = 3'b101;
    localparam logic [2:0] OP_J    = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    localparam logic [1:0] SELPC_INC = 2'b00;
    localparam logic [1:0] SELPC_REL = 2'b01;
    localparam logic [1:0] SELPC_ABS = 2'b10;

    localparam logic [2:0] ULA_ADD   = 3'b000;
    localparam logic [2:0] ULA_SUB   = 3'b001;
    localparam logic [2:0] ULA_PASSB = 3'b111;

    function automatic logic [2:0] ula_da_op(input logic [2:0] op);
        if (op == OP_SUB || op == OP_BEQ) return ULA_SUB;
        if (op == OP_LI) return ULA_PASSB;
        return ULA_ADD;
    endfunction

endpackage

// File: rtl/unidade_controle_multiciclo_decodificador.sv
// Combinational strobe decoder: (state, opcode, MemPronta, Zero)
// to datapath control signals.
module decodificador_controle
    import pacote_controle::*;
(
    input  estado_t    i_estado,
    input  logic [2:0] i_opcode,
    input  logic       i_mem_pronta,
    input  logic       i_zero,
    output logic       o_le_mem,
    output logic       o_escreve_mem,
    output logic       o_escreve_reg,
    output logic       o_escreve_pc,
    output logic       o_carrega_ir,
    output logic [1:0] o_sel_pc,
    output logic [2:0] o_op_ula,
    output logic       o_sel_mux
);

    always_comb begin
        o_le_mem      = 1'b0;
        o_escreve_mem = 1'b0;
        o_escreve_reg = 1'b0;
        o_escreve_pc  = 1'b0;
        o_carrega_ir  = 1'b0;
        o_sel_pc      = SELPC_INC;
        o_op_ula      = ULA_ADD;
        o_sel_mux     = (i_opcode != OP_LW);
        unique case (i_estado)
            BUSCA: begin
                o_le_mem     = 1'b1;
                o_carrega_ir = i_mem_pronta;
                o_escreve_pc = i_mem_pronta;
            end
            EXECUTA: begin
                o_op_ula = ula_da_op(i_opcode);
                if (i_opcode == OP_BEQ && i_zero) begin
                    o_escreve_pc = 1'b1;
                    o_sel_pc     = SELPC_REL;
                end else if (i_opcode == OP_J) begin
                    o_escreve_pc = 1'b1;
                    o_sel_pc     = SELPC_ABS;
                end
            end
            MEMORIA: begin
                o_le_mem      = (i_opcode == OP_LW);
                o_escreve_mem = (i_opcode == OP_SW);
            end
            ESCRITA: begin
                o_escreve_reg = 1'b1;
                o_op_ula      = ula_da_op(i_opcode);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/unidade_controle_multiciclo.sv
// Multi-cycle control unit: state register, instruction register
// and next-state logic; strobes come from decodificador_controle.
module unidade_controle_multiciclo
    import pacote_controle::*;
(
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] Instrucao,
    input  logic       MemPronta,
    input  logic       Zero,
    output logic [2:0] OpCode,
    output logic       SelMux,
    output logic [2:0] OpULA,
    output logic [1:0] SelPC,
    output logic       EscrevePC,
    output logic       CarregaIR,
    output logic       LeMem,
    output logic       EscreveMem,
    output logic       EscreveReg,
    output logic [2:0] Estado
);

    estado_t    r_estado;
    logic [7:0] r_ir;
    logic [2:0] w_op;
    logic       w_le_mem;
    logic       w_escreve_mem;
    logic       w_escreve_reg;
    logic       w_escreve_pc;
    logic       w_carrega_ir;

    assign w_op = r_ir[7:5];

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_estado <= BUSCA;
            r_ir     <= 8'h00;
        end else begin
            unique case (r_estado)
                BUSCA: begin
                    if (MemPronta) begin
                        r_ir     <= Instrucao;
                        r_estado <= DECODIFICA;
                    end
                end
                DECODIFICA: r_estado <= EXECUTA;
                EXECUTA: begin
                    if (w_op == OP_LW || w_op == OP_SW)
                        r_estado <= MEMORIA;
                    else if (w_op == OP_HALT)
                        r_estado <= PARADO;
                    else if (w_op == OP_BEQ || w_op == OP_J)
                        r_estado <= BUSCA;
                    else
                        r_estado <= ESCRITA;
                end
                MEMORIA: begin
                    if (MemPronta)
                        r_estado <= (w_op == OP_LW) ? ESCRITA : BUSCA;
                end
                ESCRITA: r_estado <= BUSCA;
                PARADO:  r_estado <= PARADO;
                default: r_estado <= BUSCA;
            endcase
        end
    end

    decodificador_controle u_dec (
        .i_estado      (r_estado),
        .i_opcode      (w_op),
        .i_mem_pronta  (MemPronta),
        .i_zero        (Zero),
        .o_le_mem      (w_le_mem),
        .o_escreve_mem (w_escreve_mem),
        .o_escreve_reg (w_escreve_reg),
        .o_escreve_pc  (w_escreve_pc),
        .o_carrega_ir  (w_carrega_ir),
        .o_sel_pc      (SelPC),
        .o_op_ula      (OpULA),
        .o_sel_mux     (SelMux)
    );

    // Reset state is BUSCA, which would request memory; mask strobes
    assign LeMem      = w_le_mem      & ~Reset;
    assign EscreveMem = w_escreve_mem & ~Reset;
    assign EscreveReg = w_escreve_reg & ~Reset;
    assign EscrevePC  = w_escreve_pc  & ~Reset;
    assign CarregaIR  = w_carrega_ir  & ~Reset;
    assign OpCode     = w_op;
    assign Estado     = r_estado;

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Bench for unidade_controle_multiciclo: per-instruction cycle traces
// built from the instruction rules, compared cycle by cycle.
module tb_unidade_controle_multiciclo;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [7:0] Instrucao;
    logic       MemPronta;
    logic       Zero;
    logic [2:0] OpCode;
    logic       SelMux;
    logic [2:0] OpULA;
    logic [1:0] SelPC;
    logic       EscrevePC;
    logic       CarregaIR;
    logic       LeMem;
    logic       EscreveMem;
    logic       EscreveReg;
    logic [2:0] Estado;

    unidade_controle_multiciclo dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Instrucao  (Instrucao),
        .MemPronta  (MemPronta),
        .Zero       (Zero),
        .OpCode     (OpCode),
        .SelMux     (SelMux),
        .OpULA      (OpULA),
        .SelPC      (SelPC),
        .EscrevePC  (EscrevePC),
        .CarregaIR  (CarregaIR),
        .LeMem      (LeMem),
        .EscreveMem (EscreveMem),
        .EscreveReg (EscreveReg),
        .Estado     (Estado)
    );

    always #5 Clock = ~Clock;

    int n_tests = 0;
    int n_fail  = 0;
    logic [2:0] last_op;

    typedef struct {
        logic [16:0] exp;
        logic        mp;
        logic        z;
        logic [7:0]  ins;
    } passo_t;

    passo_t q[$];

    logic [16:0] w_obs;
    assign w_obs = {Estado, LeMem, EscreveMem, EscreveReg, EscrevePC,
                    CarregaIR, SelPC, OpULA, SelMux, OpCode};

    function automatic logic [16:0] vec(
        input logic [2:0] est, input logic lm, input logic em,
        input logic er, input logic epc, input logic cir,
        input logic [1:0] spc, input logic [2:0] ula,
        input logic sm, input logic [2:0] opc);
        return {est, lm, em, er, epc, cir, spc, ula, sm, opc};
    endfunction

    function automatic logic [2:0] ula_ref(input logic [2:0] op);
        case (op)
            3'b001, 3'b101: return 3'b001;
            3'b010:         return 3'b111;
            default:        return 3'b000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [16:0] obs,
                         input logic [16:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [16:0] e, input logic mp,
                        input logic z, input logic [7:0] ins);
        passo_t p;
        p.exp = e;
        p.mp  = mp;
        p.z   = z;
        p.ins = ins;
        q.push_back(p);
    endtask

    // Expected trace for one instruction from the ISA rules
    task automatic build(input logic [7:0] ins, input int fw,
                         input int mw, input logic z);
        logic [2:0] op;
        logic       sm_old, sm, take, jmp;
        logic [1:0] spc;
        op     = ins[7:5];
        sm_old = (last_op != 3'b011);
        sm     = (op != 3'b011);
        for (int i = 0; i < fw; i++)
            push(vec(3'd0, 1, 0, 0, 0, 0, 2'b00, 3'b000, sm_old, last_op),
                 1'b0, 1'($urandom), 8'($urandom));
        push(vec(3'd0, 1, 0, 0, 1, 1, 2'b00, 3'b000, sm_old, last_op),
             1'b1, 1'($urandom), ins);
        push(vec(3'd1, 0, 0, 0, 0, 0, 2'b00, 3'b000, sm, op),
             1'($urandom), 1'($urandom), 8'($urandom));
        take = (op == 3'b101) && z;
        jmp  = (op == 3'b110);
        spc  = take ? 2'b01 : (jmp ? 2'b10 : 2'b00);
        push(vec(3'd2, 0, 0, 0, take | jmp, 0, spc, ula_ref(op), sm, op),
             1'($urandom), z, 8'($urandom));
        if (op == 3'b011 || op == 3'b100) begin
            for (int i = 0; i <= mw; i++)
                push(vec(3'd3, op == 3'b011, op == 3'b100, 0, 0, 0,
                         2'b00, 3'b000, sm, op),
                     i == mw, 1'($urandom), 8'($urandom));
        end
        if (op <= 3'b011)
            push(vec(3'd4, 0, 0, 1, 0, 0, 2'b00, ula_ref(op), sm, op),
                 1'($urandom), 1'($urandom), 8'($urandom));
        if (op == 3'b111)
            for (int i = 0; i < 20; i++)
                push(vec(3'd5, 0, 0, 0, 0, 0, 2'b00, 3'b000, sm, op),
                     1'($urandom), 1'($urandom), 8'($urandom));
        last_op = op;
    endtask

    task automatic run(input string tag);
        passo_t p;
        while (q.size() > 0) begin
            p = q.pop_front();
            MemPronta = p.mp;
            Zero      = p.z;
            Instrucao = p.ins;
            @(negedge Clock);
            check(tag, w_obs, p.exp);
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        #1;
        check("reset_async", w_obs,
              vec(3'd0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 1'b1, 3'b000));
        @(posedge Clock);
        #1;
        check("reset_hold", w_obs,
              vec(3'd0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 1'b1, 3'b000));
        Reset   = 1'b0;
        last_op = 3'b000;
    endtask

    initial begin
        Reset     = 1'b1;
        MemPronta = 1'b1;
        Zero      = 1'b0;
        Instrucao = 8'h00;
        last_op   = 3'b000;
        @(posedge Clock);
        #1;
        do_reset();

        build(8'h05, 0, 0, 1'b0); run("add");
        build(8'h4A, 0, 0, 1'b0); run("li");
        build(8'h61, 0, 3, 1'b0); run("lw_wait");
        build(8'hA3, 0, 0, 1'b1); run("beq_taken");
        build(8'hA3, 0, 0, 1'b0); run("beq_not");
        build(8'hC7, 2, 0, 1'b0); run("j_fetchwait");
        build(8'h82, 0, 1, 1'b0); run("sw");
        build(8'hE0, 0, 0, 1'b0); run("halt");

        do_reset();

        // Abandon a SUB in ESCRITA with an asynchronous reset
        build(8'h25, 1, 0, 1'b0);
        void'(q.pop_back());
        run("sub_pre");
        check("sub_escrita", w_obs,
              vec(3'd4, 0, 0, 1, 0, 0, 2'b00, 3'b001, 1'b1, 3'b001));
        Reset = 1'b1;
        #1;
        check("abort_async", w_obs,
              vec(3'd0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 1'b1, 3'b000));
        @(posedge Clock);
        #1;
        check("abort_edge", w_obs,
              vec(3'd0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 1'b1, 3'b000));
        Reset   = 1'b0;
        last_op = 3'b000;

        for (int k = 0; k < 40; k++) begin
            build({3'($urandom_range(0, 6)), 5'($urandom)},
                  $urandom_range(0, 2), $urandom_range(0, 3),
                  1'($urandom));
            run("random");
        end

        build(8'hFF, 1, 0, 1'b0); run("halt_final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
